// File: rtl/multi_adder_with_flow_control.sv
// multi_adder_with_flow_control
// N-input unsigned adder with valid/ready flow control on each input stream
// and on the result stream. Every input has its own FIFO so that producers
// can run ahead of one another. A join stage pops the head of every FIFO at
// the same time and loads the sum into a registered output stage.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_vld    per-stream valid (bit i = stream i)
//   in_rdy    per-stream ready (driven from registered FIFO state only)
//   in_data   packed operands, stream i at [i*width +: width]
//   sum_vld   result valid
//   sum_rdy   result ready from the consumer
//   sum_data  unsigned sum, width+$clog2(n_inputs) bits
module multi_adder_with_flow_control #(
  parameter int unsigned width      = 8,
  parameter int unsigned n_inputs   = 4,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [n_inputs-1:0]                in_vld,
  output logic [n_inputs-1:0]                in_rdy,
  input  logic [n_inputs*width-1:0]          in_data,
  output logic                               sum_vld,
  input  logic                               sum_rdy,
  output logic [width+$clog2(n_inputs)-1:0]  sum_data
);

  localparam int unsigned SW = width + $clog2(n_inputs);
  localparam int unsigned PW = $clog2(fifo_depth);
  localparam int unsigned CW = $clog2(fifo_depth + 1);

  // FIFO storage and bookkeeping, one set per stream
  logic [width-1:0] mem_q    [n_inputs][fifo_depth];
  logic [PW-1:0]    wr_ptr_q [n_inputs];
  logic [PW-1:0]    wr_ptr_d [n_inputs];
  logic [PW-1:0]    rd_ptr_q [n_inputs];
  logic [PW-1:0]    rd_ptr_d [n_inputs];
  logic [CW-1:0]    count_q  [n_inputs];
  logic [CW-1:0]    count_d  [n_inputs];

  logic [n_inputs-1:0] full;
  logic [n_inputs-1:0] nonempty;
  logic [n_inputs-1:0] push;
  logic                all_vld;
  logic                out_free;
  logic                fire;

  logic          sum_vld_q, sum_vld_d;
  logic [SW-1:0] sum_data_q, sum_data_d;
  logic [SW-1:0] head_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Depth need not be a power of two, so wrap explicitly.
    return (p == PW'(fifo_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int unsigned i = 0; i < n_inputs; i++) begin
      full[i]     = (count_q[i] == CW'(fifo_depth));
      nonempty[i] = (count_q[i] != '0);
    end
  end

  // Ready depends only on registered occupancy and rst.
  assign in_rdy   = ~full & {n_inputs{~rst}};
  assign push     = in_vld & in_rdy;
  assign all_vld  = &nonempty;
  assign out_free = ~sum_vld_q | sum_rdy;
  assign fire     = all_vld & out_free;

  always_comb begin
    head_sum = '0;
    for (int unsigned i = 0; i < n_inputs; i++) begin
      head_sum = head_sum + SW'(mem_q[i][rd_ptr_q[i]]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < n_inputs; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (fire)    rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      case ({push[i], fire})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_comb begin
    sum_vld_d  = sum_vld_q;
    sum_data_d = sum_data_q;
    if (fire) begin
      sum_vld_d  = 1'b1;
      sum_data_d = head_sum;
    end else if (sum_rdy) begin
      sum_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < n_inputs; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      sum_vld_q  <= 1'b0;
      sum_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < n_inputs; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      sum_vld_q  <= sum_vld_d;
      sum_data_q <= sum_data_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < n_inputs; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*width +: width];
    end
  end

  assign sum_vld  = sum_vld_q;
  assign sum_data = sum_data_q;

endmodule

// File: tb/tb_multi_adder_with_flow_control.sv
module tb_multi_adder_with_flow_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_vld;
  logic [3:0]  in_rdy;
  logic [31:0] in_data;
  logic        sum_vld;
  logic        sum_rdy;
  logic [9:0]  sum_data;

  int total = 0;
  int bad   = 0;
  int takes = 0;
  int exp_q[$];

  multi_adder_with_flow_control #(
    .width(8),
    .n_inputs(4),
    .fifo_depth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .in_data(in_data),
    .sum_vld(sum_vld),
    .sum_rdy(sum_rdy),
    .sum_data(sum_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int a0, input int a1, input int a2, input int a3);
    in_data = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endtask

  // Checks any result handshaking in the current cycle, then advances one edge.
  task automatic take_cycle(input string tag);
    if (sum_vld && sum_rdy) begin
      takes++;
      if (exp_q.size() == 0) chk({tag, "_extra"}, 32'(sum_vld), 0);
      else                   chk(tag, 32'(sum_data), exp_q.pop_front());
    end
    step();
  endtask

  task automatic drain(input string tag, input int bound);
    for (int c = 0; c < bound && exp_q.size() != 0; c++) take_cycle(tag);
    chk({tag, "_left"}, exp_q.size(), 0);
    repeat (3) take_cycle(tag);
  endtask

  initial begin
    int acc;
    int t0;
    int rdy_drops;
    int a, b, c, d;

    rst = 1'b1; in_vld = '0; in_data = '0; sum_rdy = 1'b0;
    #1;
    chk("rst_in_rdy_during", 32'(in_rdy), 0);
    step(); step();
    chk("rst_sum_vld", 32'(sum_vld), 0);
    chk("rst_sum_data", 32'(sum_data), 0);
    chk("rst_in_rdy_held", 32'(in_rdy), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_rdy", 32'(in_rdy), 4'hF);

    // Single set with latency check
    sum_rdy = 1'b1;
    in_vld = 4'hF; set_ops(1, 2, 3, 4);
    step();
    in_vld = '0;
    chk("single_lat_vld0", 32'(sum_vld), 0);
    step();
    chk("single_vld", 32'(sum_vld), 1);
    chk("single_data", 32'(sum_data), 10);
    step();
    chk("single_vld_drop", 32'(sum_vld), 0);

    // Max operands: no wrap in the 10-bit result
    in_vld = 4'hF; set_ops(255, 255, 255, 255);
    step();
    in_vld = '0;
    step();
    chk("max_vld", 32'(sum_vld), 1);
    chk("max_data", 32'(sum_data), 1020);
    step();
    chk("max_vld_drop", 32'(sum_vld), 0);

    // Skewed arrival: stream 0 runs ahead until its FIFO fills
    for (int k = 1; k <= 4; k++) begin
      in_vld = 4'b0001; set_ops(k, 0, 0, 0);
      take_cycle("skew_idle");
    end
    in_vld = '0;
    chk("skew_rdy_full0", 32'(in_rdy), 4'b1110);
    chk("skew_no_vld", 32'(sum_vld), 0);
    exp_q = '{61, 72, 83, 94, 105};
    for (int j = 0; j < 5; j++) begin
      int k;
      k = j + 1;
      // stream0 joins with its 5th operand once it has space again
      in_vld = (j == 4) ? 4'b1111 : 4'b1110;
      set_ops(5, 8 + 2*k, 17 + 3*k, 25 + 5*k);
      take_cycle("skew_sum");
    end
    in_vld = '0;
    drain("skew_drain", 10);

    // Backpressure: 1 result held plus fifo_depth per stream
    sum_rdy = 1'b0;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      in_vld = 4'hF;
      set_ops(acc + 1, acc + 1, acc + 1, acc + 1);
      if (in_rdy == 4'hF) begin
        exp_q.push_back(4 * (acc + 1));
        acc++;
      end
      take_cycle("bp_fill");
    end
    in_vld = '0;
    chk("bp_accepted", acc, 5);
    chk("bp_rdy_low", 32'(in_rdy), 0);
    chk("bp_hold_vld", 32'(sum_vld), 1);
    chk("bp_hold_data", 32'(sum_data), 4);
    step();
    chk("bp_hold_data2", 32'(sum_data), 4);
    sum_rdy = 1'b1;
    drain("bp_drain", 12);

    // Throughput: one result per cycle after a 2-cycle fill
    t0 = takes;
    rdy_drops = 0;
    for (int j = 0; j < 100; j++) begin
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255)); d = int'($urandom_range(0, 255));
      in_vld = 4'hF; set_ops(a, b, c, d);
      if (in_rdy != 4'hF) rdy_drops++;
      exp_q.push_back(a + b + c + d);
      take_cycle("tput_sum");
    end
    in_vld = '0;
    chk("tput_rdy_drops", rdy_drops, 0);
    chk("tput_takes", takes - t0, 98);
    drain("tput_drain", 6);

    // Reset mid-operation with buffered operands and a pending sum
    sum_rdy = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      in_vld = 4'hF; set_ops(j, j, j, j);
      step();
    end
    in_vld = '0;
    chk("mid_pre_vld", 32'(sum_vld), 1);
    rst = 1'b1;
    #1;
    chk("mid_rdy_during", 32'(in_rdy), 0);
    step();
    chk("mid_vld_cleared", 32'(sum_vld), 0);
    chk("mid_rdy_held", 32'(in_rdy), 0);
    rst = 1'b0;
    #1;
    chk("mid_release_rdy", 32'(in_rdy), 4'hF);
    sum_rdy = 1'b1;
    exp_q = '{8};
    in_vld = 4'hF; set_ops(7, 0, 0, 1);
    take_cycle("mid_new");
    in_vld = '0;
    drain("mid_new", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
